// File: rtl/serial_to_parallel8.sv
// serial_to_parallel8: assembles a serial bit stream into WIDTH-bit words held in a 1-entry valid/ready buffer.
//   clk, reset (sync, active-high); in_valid/in_bit serial input (no backpressure);
//   out_ready/out_valid/out_data word handshake; out_nonzero = OR of presented word;
//   busy = partial word in progress; overrun = one-cycle pulse when a completed word is dropped.
module serial_to_parallel8 #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_nonzero,
  output logic             busy,
  output logic             overrun
);
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0] count, count_n;
  logic [WIDTH-1:0] asm_q, asm_n, shifted, data_n;
  logic full, full_n, nz, nz_n, ovr_n, done, hs, load;
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      asm_q    <= '0;
      full     <= 1'b0;
      out_data <= '0;
      nz       <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      count    <= count_n;
      asm_q    <= asm_n;
      full     <= full_n;
      out_data <= data_n;
      nz       <= nz_n;
      overrun  <= ovr_n;
    end
  end
  // A completed word is loaded when the buffer is empty or is being drained in the same cycle.
  always_comb begin
    shifted = MSB_FIRST ? {asm_q[WIDTH-2:0], in_bit} : {in_bit, asm_q[WIDTH-1:1]};
    done    = in_valid && count == CW'(WIDTH - 1);
    hs      = full && out_ready;
    load    = done && (!full || hs);
    count_n = !in_valid ? count : done ? '0 : count + 1'b1;
    asm_n   = !in_valid ? asm_q : done ? '0 : shifted;
    full_n  = load || (full && !hs);
    data_n  = load ? shifted : out_data;
    nz_n    = load ? |shifted : nz;
    ovr_n   = done && full && !hs;
  end
  assign out_valid   = full;
  assign out_nonzero = full && nz;
  assign busy        = count != '0;
endmodule

// File: tb/tb_serial_to_parallel8.sv
// tb_serial_to_parallel8: checks MSB-first and LSB-first instances against a queue-based reference model.
module tb_serial_to_parallel8;
  logic clk = 1'b0, reset, in_valid, in_bit, out_ready;
  logic vm, nm, bm, om, vl, nl, bl, ol;
  logic [7:0] dm, dl;
  bit q[$];
  logic m_valid, m_ovr;
  logic [7:0] m_dm, m_dl;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  serial_to_parallel8 #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .out_ready(out_ready),
    .out_valid(vm), .out_data(dm), .out_nonzero(nm), .busy(bm), .overrun(om));
  serial_to_parallel8 #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .out_ready(out_ready),
    .out_valid(vl), .out_data(dl), .out_nonzero(nl), .busy(bl), .overrun(ol));
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic v, input logic b, input logic r, input logic rst);
    logic hs, done;
    logic [7:0] wm, wl;
    reset = rst; in_valid = v; in_bit = b; out_ready = r;
    @(posedge clk);
    hs = m_valid && r;
    done = 1'b0;
    m_ovr = 1'b0;
    wm = '0; wl = '0;
    if (rst) begin
      q.delete(); m_valid = 1'b0; m_dm = '0; m_dl = '0;
    end else begin
      if (v) begin
        q.push_back(b);
        if (q.size() == 8) begin
          done = 1'b1;
          for (int i = 0; i < 8; i++) begin
            wm = wm + (8'(q[i]) << (7 - i));
            wl = wl + (8'(q[i]) << i);
          end
          q.delete();
        end
      end
      if (done && (!m_valid || hs)) begin
        m_valid = 1'b1; m_dm = wm; m_dl = wl;
      end else if (done) m_ovr = 1'b1;
      else if (hs) m_valid = 1'b0;
    end
    #1;
    chk("m_valid", 8'(vm), 8'(m_valid));
    chk("m_data", dm, m_dm);
    chk("m_nonzero", 8'(nm), 8'(m_valid && m_dm != 0));
    chk("m_busy", 8'(bm), 8'(q.size() != 0));
    chk("m_overrun", 8'(om), 8'(m_ovr));
    chk("l_valid", 8'(vl), 8'(m_valid));
    chk("l_data", dl, m_dl);
    chk("l_nonzero", 8'(nl), 8'(m_valid && m_dl != 0));
    chk("l_busy", 8'(bl), 8'(q.size() != 0));
    chk("l_overrun", 8'(ol), 8'(m_ovr));
  endtask
  task automatic send(input logic [7:0] w, input logic r, input logic r_last);
    for (int i = 7; i >= 0; i--) step(1'b1, w[i], i == 0 ? r_last : r, 1'b0);
  endtask
  initial begin
    m_valid = 1'b0; m_ovr = 1'b0; m_dm = '0; m_dl = '0;
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    chk("rst_valid", 8'(vm), 8'h00);
    chk("rst_data", dm, 8'h00);
    send(8'h55, 0, 0);
    chk("t1_data", dm, 8'h55);
    chk("t1_valid", 8'(vm), 8'h01);
    chk("t1_nz", 8'(nm), 8'h01);
    chk("t1_busy", 8'(bm), 8'h00);
    step(0, 0, 1, 0);
    chk("t1_drain", 8'(vm), 8'h00);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0);
      if (i < 7) chk("t2_no_early", 8'(vm), 8'h00);
      step(0, 0, 0, 0);
      if (i < 7) chk("t2_busy_gap", 8'(bm), 8'h01);
    end
    chk("t2_data", dm, 8'h00);
    chk("t2_nz", 8'(nm), 8'h00);
    chk("t2_valid", 8'(vm), 8'h01);
    step(0, 0, 1, 0);
    send(8'hA5, 0, 0);
    send(8'h3C, 0, 0);
    chk("t3_overrun", 8'(om), 8'h01);
    chk("t3_data", dm, 8'hA5);
    step(0, 0, 1, 0);
    chk("t3_ovr_pulse", 8'(om), 8'h00);
    chk("t3_drain", 8'(vm), 8'h00);
    send(8'hA5, 0, 0);
    send(8'h3C, 0, 1);
    chk("t4_data", dm, 8'h3C);
    chk("t4_valid", 8'(vm), 8'h01);
    chk("t4_overrun", 8'(om), 8'h00);
    step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 1);
    chk("t5_busy", 8'(bm), 8'h00);
    chk("t5_valid", 8'(vm), 8'h00);
    send(8'h81, 0, 0);
    chk("t5_data", dm, 8'h81);
    step(0, 0, 1, 0);
    send(8'h80, 0, 0);
    chk("t6_lsb_data", dl, 8'h01);
    chk("t6_lsb_nz", 8'(nl), 8'h01);
    step(0, 0, 1, 0);
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 99) == 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_to_parallel8.md
# serial_to_parallel8

Assembles a serial bit stream, one bit per accepted cycle, into parallel words of WIDTH bits, and presents each completed word on a valid/ready output port. It is the expanding counterpart of the OR8WAY reduction gate. It sits between a 1-bit input source (keyboard/serial pin model) and the 8-bit datapath. It also reports an OR-reduction of every presented word as a zero/non-zero flag.

## Interface
- WIDTH, 8: bits per word; legal range 2..16.
- MSB_FIRST, 1: 1 means the first received bit lands in out_data[WIDTH-1]; 0 means it lands in out_data[0].

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high; sampled on the clk rising edge.
- in_valid  input  1  in_bit is valid this cycle; always accepted, with no input backpressure.
- in_bit  input  1  serial data bit.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_valid  output  1  out_data holds a completed, unconsumed word.
- out_data  output  WIDTH  completed word; stable while out_valid=1.
- out_nonzero  output  1  OR of all out_data bits; valid when out_valid=1, otherwise 0.
- busy  output  1  partial word in progress (bit count ≠ 0).
- overrun  output  1  one-cycle pulse: a word completed while the holding register was full and not being drained; that word is discarded.

## Operation
- Assembly FSM:
  - IDLE: count=0, busy=0.
  - SHIFT: count 1..WIDTH-1, busy=1.
- Each cycle with in_valid=1, the bit is shifted into the assembly register, in the direction set by MSB_FIRST.
- count increments modulo WIDTH. count wraps to 0 (IDLE) when the WIDTH-th bit is accepted; the word is complete on that edge.
- Cycles with in_valid=0 hold count and the partial word. There is no timeout.
- The holding register is a separate 1-entry buffer with two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- A handshake occurs on any cycle with out_valid=1 and out_ready=1. FULL goes to EMPTY unless a new word completes in the same cycle.
- Word completion while EMPTY: load the word and go FULL.
- Word completion while FULL, with a handshake in the same cycle: load the new word and stay FULL. No overrun and no bubble.
- Word completion while FULL, with no handshake: keep the old word, discard the new word, and pulse overrun for one cycle. Assembly restarts from count=0 either way.
- out_nonzero is computed from the holding register (registered path, not from the assembly register).
- reset (synchronous):
  - count=0 and assembly register=0.
  - Holding register EMPTY and out_data=0.
  - out_valid=0, out_nonzero=0, busy=0, overrun=0.
  - Reset overrides any simultaneous in_valid or handshake. A partial word is discarded on reset mid-operation.

## Timing
- All outputs are registered, with no combinational path from any input to any output.
- Latency: out_valid rises on the edge that accepts the WIDTH-th bit, so it is visible in the cycle after that bit is presented.
- Throughput: one word per WIDTH accepted bits. A consumer holding out_ready=1 sees back-to-back words with no stall.
- out_data and out_nonzero change only on a load edge, or to 0 on reset.
- busy goes to 1 on the edge accepting bit 1. It returns to 0 on the edge accepting bit WIDTH.
- overrun is high for exactly one cycle per discarded word.

## Test plan
1. Reset, then MSB_FIRST=1 with bits 0,1,0,1,0,1,0,1 on 8 consecutive cycles.
   - Required: out_valid=1 the next cycle, out_data=8'h55, out_nonzero=1, busy=0.
   - With out_ready=1, out_valid drops after 1 cycle.
2. Eight 0 bits, with in_valid gapped (valid every other cycle).
   - Required: out_data=8'h00 and out_nonzero=0 after the 8th accepted bit.
   - busy stays 1 across the gaps.
   - No early completion.
3. Backpressure: send 8'hA5 with out_ready=0, then send 8'h3C with out_ready still 0.
   - Required: out_data stays 8'hA5.
   - overrun pulses 1 cycle on the 16th bit.
   - After out_ready=1, out_valid=0.
4. Simultaneous events: out_ready asserted exactly on the cycle the second word's last bit is accepted.
   - Required: out_data goes 8'hA5 → 8'h3C, out_valid stays 1, overrun=0.
5. Reset mid-word: 4 bits 1,1,1,1, then reset 1 cycle, then 8 bits of 8'h81.
   - Required: busy=0 after reset and out_valid=0.
   - Result is out_data=8'h81 (no residue from the first 4 bits).
6. MSB_FIRST=0, WIDTH=8, bits 1,0,0,0,0,0,0,0.
   - Required: out_data=8'h01, out_nonzero=1.
